sr_s2p_rx: RTL

SR_S2P_RX -- requirements
Module: sr_s2p_rx

---
 rtl/sr_pkg.sv | 16 +
 rtl/sr_s2p_outreg.sv | 41 ++++
 rtl/sr_s2p_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the serial/parallel converters (transmitter and receiver).
package sr_pkg;

    localparam int WORD_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sr_state_e;

    // Frame length in bits: the data word plus an optional trailing parity bit.
    function automatic int sr_frame_bits(input int width, input bit parity_en);
        return width + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/sr_s2p_outreg.sv
// Single-entry valid/ready holding register; a word arriving while full and not
// being drained is dropped and flagged with a one-cycle overrun pulse.
module sr_s2p_outreg
    import sr_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overrun
);

    logic load;
    logic accept;

    // Loading while full is allowed only when the held word leaves on the same edge.
    assign load   = in_valid && (!out_valid || out_ready);
    assign accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= in_valid && out_valid && !out_ready;
            if (load) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sr_s2p_rx.sv
// Serial-to-parallel receiver, MSB first, framed by start.
// Optional even-parity trailer enabled by macro SR_S2P_RX_PARITY_EN.
//
// state | meaning
// IDLE  | waiting for start; data_in ignored
// SHIFT | frame in progress; cnt = frame bits still to capture
module sr_s2p_rx
    import sr_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err
);

`ifdef SR_S2P_RX_PARITY_EN
    localparam int FRAME_BITS = sr_frame_bits(WIDTH, 1'b1);
`else
    localparam int FRAME_BITS = sr_frame_bits(WIDTH, 1'b0);
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 1);

    sr_state_e        state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word_data;
    logic             word_stb;
    logic             ferr_nx;
    logic             last_bit;
`ifdef SR_S2P_RX_PARITY_EN
    logic             perr_nx;
    logic             perr_q;
`endif

    assign shifted  = {shreg[WIDTH-2:0], data_in};
    assign last_bit = (state == SHIFT) && (cnt == CNT_W'(1));

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        shreg_nx  = shreg;
        word_stb  = 1'b0;
        word_data = shifted;
        ferr_nx   = 1'b0;
`ifdef SR_S2P_RX_PARITY_EN
        perr_nx   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nx = {{(WIDTH-1){1'b0}}, data_in};
                    cnt_nx   = CNT_W'(FRAME_BITS - 1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
`ifdef SR_S2P_RX_PARITY_EN
                    // Final bit is the parity trailer; the word is already complete in shreg.
                    word_data = shreg;
                    word_stb  = ((^shreg) == data_in);
                    perr_nx   = ((^shreg) != data_in);
`else
                    word_stb  = 1'b1;
`endif
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    // A start on the final bit also opens the next frame with this bit as MSB.
                    if (start) begin
                        shreg_nx = {{(WIDTH-1){1'b0}}, data_in};
                        cnt_nx   = CNT_W'(FRAME_BITS - 1);
                        state_nx = SHIFT;
                    end
                end else if (start) begin
                    ferr_nx  = 1'b1;
                    shreg_nx = {{(WIDTH-1){1'b0}}, data_in};
                    cnt_nx   = CNT_W'(FRAME_BITS - 1);
                end else begin
                    shreg_nx = shifted;
                    cnt_nx   = cnt - CNT_W'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            shreg     <= shreg_nx;
            frame_err <= ferr_nx;
        end
    end

`ifdef SR_S2P_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_nx;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state == SHIFT);

    sr_s2p_outreg #(
        .WIDTH(WIDTH)
    ) u_outreg (
        .clk      (clk),
        .reset    (reset),
        .in_valid (word_stb),
        .in_data  (word_data),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .overrun  (overrun)
    );

endmodule
